// File: rtl/mpd_tx_engine.sv
// mpd_tx_engine: transmit side of the MPD packet dispatcher.
// - Drains the to-invalidate FIFO by releasing those slots.
// - Drains the to-send FIFO by streaming each slot's frame from the PRT
//   buffer to the MAC, then releasing the slot.
// - The PRT read has one cycle of latency. A 2-entry skid buffer plus a
//   bypass path let the MAC take one byte per cycle while keeping tx_data
//   stable during back-pressure.
module mpd_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int SLOT_W     = 2,
    parameter int LEN_W      = 11,
    parameter int FRAME_SIZE = 1500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_slot_valid,
    input  logic [SLOT_W-1:0]     send_slot,
    output logic                  send_slot_ready,
    input  logic                  inv_slot_valid,
    input  logic [SLOT_W-1:0]     inv_slot,
    output logic                  inv_slot_ready,
    output logic [SLOT_W-1:0]     prt_rd_slot,
    input  logic [LEN_W-1:0]      prt_frame_len,
    output logic                  prt_rd_en,
    output logic [LEN_W-1:0]      prt_rd_addr,
    input  logic [DATA_WIDTH-1:0] prt_rd_data,
    output logic                  prt_free_en,
    output logic [SLOT_W-1:0]     prt_free_slot,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  tx_frame_done,
    output logic [15:0]           frames_sent,
    output logic [15:0]           frames_dropped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_FREE
    } state_e;

    localparam logic [LEN_W-1:0] FRAME_MAX = LEN_W'(FRAME_SIZE);

    state_e                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      rd_ptr_q;
    logic                  inflight_q;       // a PRT read returns data this cycle
    logic                  inflight_last_q;  // ... and it is the frame's final byte
    logic [1:0]            count_q;          // live skid entries
    logic                  wr_idx_q;
    logic                  rd_idx_q;
    logic [DATA_WIDTH-1:0] skid_data_q [2];
    logic                  skid_last_q [2];
    logic [15:0]           sent_q;
    logic [15:0]           dropped_q;

    logic                  len_bad;
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic [1:0]            occupancy;
    logic                  rd_issue;
    logic                  push;
    logic                  pop;
    logic                  last_hs;
    logic                  drop_inc;
    logic                  sent_inc;

    // The head comes from the skid buffer when it holds data, else straight
    // from the PRT read port. That bypass puts the first byte on the MAC one
    // cycle after its read.
    assign len_bad    = (prt_frame_len == '0) || (prt_frame_len > FRAME_MAX);
    assign head_valid = (count_q != 2'd0) || inflight_q;
    assign head_data  = (count_q != 2'd0) ? skid_data_q[rd_idx_q] : prt_rd_data;
    assign head_last  = (count_q != 2'd0) ? skid_last_q[rd_idx_q] : inflight_last_q;
    assign occupancy  = count_q + {1'b0, inflight_q};
    assign rd_issue   = (state_q == S_STREAM) && (rd_ptr_q < len_q) && (occupancy < 2'd2);
    // A returning byte is stored unless the bypass hands it to the MAC at once.
    assign push       = inflight_q && !((count_q == 2'd0) && tx_ready);
    assign pop        = (state_q == S_STREAM) && (count_q != 2'd0) && tx_ready;
    assign last_hs    = (state_q == S_STREAM) && head_valid && tx_ready && head_last;

    assign prt_rd_slot    = slot_q;
    assign prt_rd_addr    = rd_ptr_q;
    assign frames_sent    = sent_q;
    assign frames_dropped = dropped_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; invalidations only get served from IDLE.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!inv_slot_valid && send_slot_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD:   state_d = len_bad ? S_IDLE : S_STREAM;
            S_STREAM: begin
                if (last_hs) begin
                    state_d = S_FREE;
                end
            end
            S_FREE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: FIFO pops, PRT read/free strobes, MAC stream, counter events.
    always_comb begin
        send_slot_ready = 1'b0;
        inv_slot_ready  = 1'b0;
        prt_rd_en       = 1'b0;
        prt_free_en     = 1'b0;
        prt_free_slot   = '0;
        tx_valid        = 1'b0;
        tx_data         = '0;
        tx_last         = 1'b0;
        tx_frame_done   = 1'b0;
        drop_inc        = 1'b0;
        sent_inc        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (inv_slot_valid) begin
                    inv_slot_ready = 1'b1;
                    prt_free_en    = 1'b1;
                    prt_free_slot  = inv_slot;
                    drop_inc       = 1'b1;
                end else if (send_slot_valid) begin
                    send_slot_ready = 1'b1;
                end
            end
            S_LOAD: begin
                if (len_bad) begin
                    prt_free_en   = 1'b1;
                    prt_free_slot = slot_q;
                    drop_inc      = 1'b1;
                end
            end
            S_STREAM: begin
                prt_rd_en = rd_issue;
                tx_valid  = head_valid;
                if (head_valid) begin
                    tx_data = head_data;
                    tx_last = head_last;
                end
            end
            S_FREE: begin
                prt_free_en   = 1'b1;
                prt_free_slot = slot_q;
                tx_frame_done = 1'b1;
                sent_inc      = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame context, read pointer, in-flight tracking and skid occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q          <= '0;
            len_q           <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            wr_idx_q        <= 1'b0;
            rd_idx_q        <= 1'b0;
        end else begin
            if (send_slot_ready) begin
                slot_q <= send_slot;
            end
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (rd_ptr_q == len_q - LEN_W'(1));
            if (state_q == S_LOAD) begin
                len_q    <= prt_frame_len;
                rd_ptr_q <= '0;
                count_q  <= 2'd0;
                wr_idx_q <= 1'b0;
                rd_idx_q <= 1'b0;
            end else begin
                if (rd_issue) begin
                    rd_ptr_q <= rd_ptr_q + LEN_W'(1);
                end
                if (push) begin
                    wr_idx_q <= ~wr_idx_q;
                end
                if (pop) begin
                    rd_idx_q <= ~rd_idx_q;
                end
                if (push && !pop) begin
                    count_q <= count_q + 2'd1;
                end else if (pop && !push) begin
                    count_q <= count_q - 2'd1;
                end
            end
        end
    end

    // Skid storage: write the returning byte and its last flag at the tail.
    // NOTE: skid storage is not reset; count_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            skid_data_q[wr_idx_q] <= prt_rd_data;
            skid_last_q[wr_idx_q] <= inflight_last_q;
        end
    end

    // Saturating frame counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_q    <= '0;
            dropped_q <= '0;
        end else begin
            if (sent_inc && (sent_q != 16'hFFFF)) begin
                sent_q <= sent_q + 16'd1;
            end
            if (drop_inc && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

endmodule

// File: doc/mpd_tx_engine.md
# mpd_tx_engine

Transmit-side engine of the MPD (packet dispatcher). It consumes slot tags that the firewall verdict logic has placed in the to-send and to-invalidate FIFOs. For each safe slot it streams the stored frame out of the PRT packet buffer to the Ethernet MAC byte by byte, then releases the slot. For each unsafe slot it releases the slot without transmitting. It is the counterpart of the MPD receive path, which writes frames into PRT slots and posts header+tag to the firewall.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — byte width of PRT read data and MAC tx data.
- `SLOT_W`, 2 — width of a PRT slot index.
- `LEN_W`, 11 — width of frame length and byte address.
- `FRAME_SIZE`, 1500 — maximum legal frame length in bytes.

Ports:
- `clk` in 1 — single clock; all logic is on its rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `send_slot_valid` in 1 — to-send FIFO is not empty.
- `send_slot` in SLOT_W — to-send FIFO head.
- `send_slot_ready` out 1 — pop pulse to the to-send FIFO.
- `inv_slot_valid` in 1 — to-invalidate FIFO is not empty.
- `inv_slot` in SLOT_W — to-invalidate FIFO head.
- `inv_slot_ready` out 1 — pop pulse to the to-invalidate FIFO.
- `prt_rd_slot` out SLOT_W — slot being read.
- `prt_frame_len` in LEN_W — stored length of `prt_rd_slot`; combinational in the PRT.
- `prt_rd_en` out 1 — byte read request.
- `prt_rd_addr` out LEN_W — byte offset. Read data returns exactly 1 cycle after `prt_rd_en`.
- `prt_rd_data` in DATA_WIDTH — read data.
- `prt_free_en` out 1 — one-cycle slot release.
- `prt_free_slot` out SLOT_W — slot released.
- `tx_valid` out 1 — MAC byte valid.
- `tx_data` out DATA_WIDTH — MAC byte.
- `tx_last` out 1 — asserted with the final byte of the frame.
- `tx_ready` in 1 — MAC accepts the byte.
- `tx_frame_done` out 1 — one-cycle pulse after the last byte is accepted.
- `frames_sent` out 16 — count of transmitted frames.
- `frames_dropped` out 16 — count of invalidated and bad-length frames.

## Operation
FSM states: IDLE, LOAD, STREAM, FREE.

IDLE:
- If `inv_slot_valid`: pulse `inv_slot_ready`, drive `prt_free_en`/`prt_free_slot=inv_slot` in the same cycle, increment `frames_dropped`, stay in IDLE. Invalidation has priority over send when both are valid.
- Else if `send_slot_valid`: pulse `send_slot_ready`, latch `send_slot` into `prt_rd_slot`, go to LOAD.

LOAD:
- Latch `len = prt_frame_len`.
- If `len==0` or `len>FRAME_SIZE`: drop the frame. No tx activity; pulse free of the slot; `frames_dropped++`; return to IDLE.
- Else: clear the read pointer and go to STREAM.

STREAM:
- 2-entry output skid buffer; the head drives `tx_valid`/`tx_data`.
- Issue `prt_rd_en` with `prt_rd_addr = rd_ptr` when `rd_ptr < len` and (buffered + in-flight) < 2. Increment `rd_ptr` on each read.
- Returned data is written to the buffer tail.
- A buffer entry is popped on `tx_valid && tx_ready`.
- `tx_last` is asserted when the head entry is byte `len-1`. Each entry carries a last flag.
- After the last-byte handshake, go to FREE.

FREE:
- Pulse `prt_free_en` with `prt_free_slot = prt_rd_slot`.
- Pulse `tx_frame_done`; `frames_sent++`.
- Return to IDLE.

General rules:
- Invalidations arriving during LOAD, STREAM or FREE wait in their FIFO and are served in IDLE. A frame in flight is never aborted.
- Both counters saturate at 0xFFFF.
- `tx_data` and `tx_last` are held stable while `tx_valid && !tx_ready`.

## Timing
- Reset: all outputs are 0, the FSM is IDLE, the buffer is empty, `rd_ptr` is 0 and the counters are 0.
- Reset mid-frame: the frame is truncated with no `tx_last`, no free is issued (the PRT resets together with this block), and the block is in IDLE on release.
- Pop in IDLE at cycle 0 → LOAD in cycle 1 → first `prt_rd_en` in cycle 2 → first `tx_valid` in cycle 3.
- With `tx_ready` held high: 1 byte per cycle. Last byte accepted at cycle `2+len`; FREE pulses (`prt_free_en`, `tx_frame_done`) at cycle `3+len`; next pop possible at cycle `4+len`.
- Invalidation: pop and free occur in the same cycle, one per cycle while `inv_slot_valid` stays high.
- `tx_valid` never drops mid-frame unless the buffer is empty. With `tx_ready` high it never drops mid-frame.

## Test plan
- Frame of length 64 in slot 2, data = address, `tx_ready`=1:
  - `send_slot_ready` at cycle 0, first `tx_valid` at cycle 3.
  - `tx_data` = 0..63 in order, `tx_last` only on 63.
  - `prt_free_slot`=2 and `tx_frame_done` at cycle 67; `frames_sent`=1.
- Frame of length 60 with `tx_ready` toggling 1/0 each cycle:
  - Exactly 60 handshakes with data 0..59, no duplicates or gaps.
  - `tx_data` stable during stalls.
- `inv_slot_valid` (slot 1) and `send_slot_valid` (slot 3) both high in IDLE:
  - Cycle 0: `inv_slot_ready` and free of slot 1, `frames_dropped`=1.
  - Cycle 1: `send_slot_ready`; slot 3 then streams normally.
- `prt_frame_len`=0, then `prt_frame_len`=1501:
  - No `tx_valid` for either.
  - Each slot is freed; `frames_dropped`=2.
- Frame of length 1: a single byte with `tx_valid` and `tx_last` together, followed by `tx_frame_done`.
- `reset` asserted low at byte 20 of a 100-byte frame:
  - All outputs 0 immediately (asynchronous).
  - After release, a new 10-byte frame streams correctly and `frames_sent`=1.
